dispatch_buffer: RTL and testbench
==================================

DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of FIFO entries; SHALL be a power of two and at least 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 flush  input  1  pipeline flush, synchronous.
REQ-005 inst0_in, inst1_in  input  UOPBundle  uops from the rename/dispatch register; inst0 is older; each carries valid and busType.
REQ-006 stall_out  output  1  upstream stall; the rename/dispatch register holds its outputs while high.
REQ-007 alu_ready, lsu_ready, mdu_ready  input  1 each  target issue queue can accept one uop this cycle.
REQ-008 alu_uop, lsu_uop, mdu_uop  output  UOPBundle each  uop presented to each issue queue.
REQ-009 alu_fire, lsu_fire, mdu_fire  output  1 each  uop on the matching port is accepted this cycle.

Function
REQ-010 Storage SHALL be a DEPTH-entry circular FIFO: head and tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-011 stall_out SHALL be 1 when count > DEPTH-2 (fewer than two free entries), otherwise 0; it is derived from registered count only.
REQ-012 When stall_out=0 and flush=0, valid inputs SHALL be written at tail in age order; a lone valid inst1 is written at tail (compaction); tail advances by the number of valid inputs (0, 1 or 2).
REQ-013 When stall_out=1, inputs SHALL be ignored; upstream holds them.
REQ-014 head0 is the entry at head, head1 is the entry at head+1; each exists only if count exceeds its offset.
REQ-015 head0 SHALL dispatch when it exists and the ready input for its busType is 1.
REQ-016 head1 SHALL dispatch only if head0 dispatches, head1 targets a different queue from head0, and that queue's ready is 1; dispatch is strictly in order.
REQ-017 For each queue, *_uop SHALL carry the dispatching head entry, and *_fire SHALL be 1 exactly when a uop transfers to it; when *_fire=0, *_uop SHALL be all-zero.
REQ-018 Head SHALL advance by the number of dispatched uops (0 to 2). Count SHALL update as count + enqueued - dispatched in the same cycle.
REQ-019 A busType outside ALU/LSU/MDU SHALL be treated as ALU.
REQ-020 flush=1 SHALL zero count, head and tail, force all *_fire to 0, and block enqueue in that cycle; entry contents need not be cleared.
REQ-021 An empty FIFO SHALL produce all *_fire=0; a full FIFO SHALL never be overwritten.

Reset
REQ-022 rst=1 SHALL asynchronously clear head, tail, count and all entries to 0; stall_out and all *_fire are then 0, and all *_uop are zero.
REQ-023 Reset asserted mid-operation SHALL discard buffered uops with no dispatch in any cycle while rst=1.

Structure
REQ-024 The shared defines package SHALL hold UOPBundle, the busType enum (ALU, LSU, MDU) and the DISPATCH_DEPTH default constant.
REQ-025 One sub-module is natural: dispatch_fifo (circular storage, pointers and count); routing and issue-ordering logic stay in dispatch_buffer.

Verification
REQ-026 Reset, then a pair of ALU and LSU uops with all ready=1 -> both written in cycle 1; alu_fire=1 and lsu_fire=1 in cycle 2; count returns to 0.
REQ-027 Two ALU uops with alu_ready=1 -> one fire per cycle over two cycles, older uop first.
REQ-028 All ready=0 and pairs sent each cycle -> count=2, then 4; stall_out=1 once count=3 or more; no overwrite; releasing mdu_ready while head0 is ALU -> no fire.
REQ-029 inst0.valid=0 and inst1.valid=1 -> the uop lands at tail, tail+1 and count+1.
REQ-030 FIFO holding 3 entries, flush=1 in the same cycle as a valid pair and ready=1 -> no fires and no enqueue; count=0 next cycle.
REQ-031 Async rst pulsed between clock edges while count=2 -> count=0 immediately, stall_out=0, all *_fire=0.

Source files
------------

// File: rtl/dispatch_buffer_pkg.sv
// Shared definitions for the dispatch stage: uop bundle layout, issue-queue
// bus types and the default buffer depth.
package dispatch_buffer_pkg;

    localparam int DISPATCH_DEPTH = 4;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        LSU = 2'd1,
        MDU = 2'd2
    } bus_type_e;

    typedef struct packed {
        logic       valid;
        bus_type_e  busType;
        logic [7:0] tag;
        logic [31:0] payload;
    } UOPBundle;

    // Encodings that name no issue queue are routed to the ALU.
    function automatic bus_type_e normalize_bus(input bus_type_e bus);
        bus_type_e result;
        case (bus)
            LSU:     result = LSU;
            MDU:     result = MDU;
            default: result = ALU;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dispatch_buffer_fifo.sv
// Circular uop storage with head/tail pointers and an occupancy count.
// Callers guarantee enqueues never exceed free space and dequeues never exceed count.
module dispatch_fifo
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH = DISPATCH_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [1:0]    enq_count,
    input  UOPBundle      enq_data0,
    input  UOPBundle      enq_data1,
    input  logic [1:0]    deq_count,
    output UOPBundle      head0_entry,
    output UOPBundle      head1_entry,
    output logic [CW-1:0] count
);

    UOPBundle        entries [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   head_plus1;
    logic [PW-1:0]   tail_plus1;

    assign head_plus1  = head + PW'(1);
    assign tail_plus1  = tail + PW'(1);
    assign head0_entry = entries[head];
    assign head1_entry = entries[head_plus1];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_count != 2'd0) begin
                entries[tail] <= enq_data0;
            end
            if (enq_count == 2'd2) begin
                entries[tail_plus1] <= enq_data1;
            end
            tail  <= tail + PW'(enq_count);
            head  <= head + PW'(deq_count);
            count <= count + CW'(enq_count) - CW'(deq_count);
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// Dispatch buffer: decouples rename from the ALU/LSU/MDU issue queues and
// dispatches up to two uops per cycle strictly in program order.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH = DISPATCH_DEPTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  UOPBundle inst0_in,
    input  UOPBundle inst1_in,
    output logic     stall_out,
    input  logic     alu_ready,
    input  logic     lsu_ready,
    input  logic     mdu_ready,
    output UOPBundle alu_uop,
    output UOPBundle lsu_uop,
    output UOPBundle mdu_uop,
    output logic     alu_fire,
    output logic     lsu_fire,
    output logic     mdu_fire
);

    logic [CW-1:0] count;
    logic [1:0]    enq_count;
    logic [1:0]    deq_count;
    UOPBundle      enq_data0;
    UOPBundle      enq_data1;
    UOPBundle      head0;
    UOPBundle      head1;
    bus_type_e     head0_bus;
    bus_type_e     head1_bus;
    logic          head0_ready;
    logic          head1_ready;
    logic          fire0;
    logic          fire1;

    function automatic logic queue_ready(input bus_type_e bus, input logic a,
                                         input logic l, input logic m);
        logic r;
        case (bus)
            LSU:     r = l;
            MDU:     r = m;
            default: r = a;
        endcase
        return r;
    endfunction

    // Stall keeps two free slots so a full pair can always be accepted.
    assign stall_out = (count > CW'(DEPTH - 2));

    // A lone valid inst1 is compacted into the first write slot.
    always_comb begin
        enq_count = 2'd0;
        enq_data0 = inst0_in;
        enq_data1 = inst1_in;
        if (!stall_out && !flush) begin
            enq_count = {1'b0, inst0_in.valid} + {1'b0, inst1_in.valid};
            if (!inst0_in.valid) begin
                enq_data0 = inst1_in;
            end
        end
    end

    dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_count   (enq_count),
        .enq_data0   (enq_data0),
        .enq_data1   (enq_data1),
        .deq_count   (deq_count),
        .head0_entry (head0),
        .head1_entry (head1),
        .count       (count)
    );

    assign head0_bus   = normalize_bus(head0.busType);
    assign head1_bus   = normalize_bus(head1.busType);
    assign head0_ready = queue_ready(head0_bus, alu_ready, lsu_ready, mdu_ready);
    assign head1_ready = queue_ready(head1_bus, alu_ready, lsu_ready, mdu_ready);

    // head1 may only go alongside head0, and only to a different queue.
    always_comb begin
        fire0 = !flush && (count != '0) && head0_ready;
        fire1 = fire0 && (count > CW'(1)) && (head1_bus != head0_bus) && head1_ready;
        deq_count = {1'b0, fire0} + {1'b0, fire1};
    end

    always_comb begin
        alu_uop  = '0;
        lsu_uop  = '0;
        mdu_uop  = '0;
        alu_fire = 1'b0;
        lsu_fire = 1'b0;
        mdu_fire = 1'b0;
        if (fire0) begin
            case (head0_bus)
                LSU:     begin lsu_uop = head0; lsu_fire = 1'b1; end
                MDU:     begin mdu_uop = head0; mdu_fire = 1'b1; end
                default: begin alu_uop = head0; alu_fire = 1'b1; end
            endcase
        end
        if (fire1) begin
            case (head1_bus)
                LSU:     begin lsu_uop = head1; lsu_fire = 1'b1; end
                MDU:     begin mdu_uop = head1; mdu_fire = 1'b1; end
                default: begin alu_uop = head1; alu_fire = 1'b1; end
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: each task drives one scenario and checks
// outputs between clock edges against hand-computed values.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    logic     clk;
    logic     rst;
    logic     flush;
    UOPBundle inst0_in;
    UOPBundle inst1_in;
    logic     stall_out;
    logic     alu_ready;
    logic     lsu_ready;
    logic     mdu_ready;
    UOPBundle alu_uop;
    UOPBundle lsu_uop;
    UOPBundle mdu_uop;
    logic     alu_fire;
    logic     lsu_fire;
    logic     mdu_fire;

    int total = 0;
    int bad   = 0;

    dispatch_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .inst0_in  (inst0_in),
        .inst1_in  (inst1_in),
        .stall_out (stall_out),
        .alu_ready (alu_ready),
        .lsu_ready (lsu_ready),
        .mdu_ready (mdu_ready),
        .alu_uop   (alu_uop),
        .lsu_uop   (lsu_uop),
        .mdu_uop   (mdu_uop),
        .alu_fire  (alu_fire),
        .lsu_fire  (lsu_fire),
        .mdu_fire  (mdu_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic UOPBundle mk(input logic [1:0] bus, input logic [7:0] tag);
        UOPBundle u;
        u.valid   = 1'b1;
        u.busType = bus_type_e'(bus);
        u.tag     = tag;
        u.payload = 32'h1000_0000 + {24'd0, tag};
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst0_in = '0;
        inst1_in = '0;
        #1;
    endtask

    task automatic set_ready(input logic a, input logic l, input logic m);
        alu_ready = a;
        lsu_ready = l;
        mdu_ready = m;
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (dut.count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", dut.count); end
        total++;
        if ({stall_out, alu_fire, lsu_fire, mdu_fire} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {stall_out, alu_fire, lsu_fire, mdu_fire});
        end
        total++;
        if ({alu_uop, lsu_uop, mdu_uop} !== '0) begin
            bad++; $display("[TB] FAIL reset_uops got=%h want=0", {alu_uop, lsu_uop, mdu_uop});
        end
    endtask

    task automatic test_pair();
        set_ready(1, 1, 1);
        inst0_in = mk(2'd0, 8'd1);
        inst1_in = mk(2'd1, 8'd2);
        #1;
        total++;
        if ({alu_fire, lsu_fire, mdu_fire} !== 3'b000) begin
            bad++; $display("[TB] FAIL pair_empty_fire got=%b want=000", {alu_fire, lsu_fire, mdu_fire});
        end
        step();
        clear_inputs();
        total++;
        if (dut.count !== 3'd2) begin bad++; $display("[TB] FAIL pair_count got=%0d want=2", dut.count); end
        total++;
        if ({alu_fire, lsu_fire, mdu_fire} !== 3'b110) begin
            bad++; $display("[TB] FAIL pair_fire got=%b want=110", {alu_fire, lsu_fire, mdu_fire});
        end
        total++;
        if (alu_uop !== mk(2'd0, 8'd1) || lsu_uop !== mk(2'd1, 8'd2) || mdu_uop !== '0) begin
            bad++; $display("[TB] FAIL pair_uops got alu=%h lsu=%h mdu=%h want tags 1,2,none", alu_uop, lsu_uop, mdu_uop);
        end
        step();
        total++;
        if (dut.count !== 3'd0) begin bad++; $display("[TB] FAIL pair_drain got=%0d want=0", dut.count); end
    endtask

    task automatic test_in_order();
        inst0_in = mk(2'd0, 8'd3);
        inst1_in = mk(2'd0, 8'd4);
        step();
        clear_inputs();
        total++;
        if (alu_fire !== 1'b1 || alu_uop !== mk(2'd0, 8'd3)) begin
            bad++; $display("[TB] FAIL order_first got fire=%b uop=%h want fire=1 tag 3", alu_fire, alu_uop);
        end
        step();
        total++;
        if (dut.count !== 3'd1 || alu_fire !== 1'b1 || alu_uop !== mk(2'd0, 8'd4)) begin
            bad++; $display("[TB] FAIL order_second got cnt=%0d fire=%b uop=%h want cnt=1 fire=1 tag 4", dut.count, alu_fire, alu_uop);
        end
        step();
        total++;
        if (dut.count !== 3'd0 || alu_fire !== 1'b0 || alu_uop !== '0) begin
            bad++; $display("[TB] FAIL order_empty got cnt=%0d fire=%b want cnt=0 fire=0", dut.count, alu_fire);
        end
    endtask

    task automatic test_stall();
        set_ready(0, 0, 0);
        inst0_in = mk(2'd0, 8'd5);
        inst1_in = mk(2'd2, 8'd6);
        step();
        total++;
        if (dut.count !== 3'd2 || stall_out !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_cnt2 got cnt=%0d stall=%b want cnt=2 stall=0", dut.count, stall_out);
        end
        inst0_in = mk(2'd0, 8'd7);
        inst1_in = mk(2'd1, 8'd8);
        step();
        total++;
        if (dut.count !== 3'd4 || stall_out !== 1'b1) begin
            bad++; $display("[TB] FAIL stall_cnt4 got cnt=%0d stall=%b want cnt=4 stall=1", dut.count, stall_out);
        end
        inst0_in = mk(2'd2, 8'd9);
        inst1_in = mk(2'd2, 8'd10);
        step();
        total++;
        if (dut.count !== 3'd4) begin bad++; $display("[TB] FAIL stall_hold got=%0d want=4", dut.count); end
        set_ready(0, 0, 1);
        total++;
        if ({alu_fire, lsu_fire, mdu_fire} !== 3'b000) begin
            bad++; $display("[TB] FAIL stall_head_block got=%b want=000", {alu_fire, lsu_fire, mdu_fire});
        end
        clear_inputs();
        set_ready(1, 0, 1);
        total++;
        if (alu_uop !== mk(2'd0, 8'd5) || mdu_uop !== mk(2'd2, 8'd6) || lsu_fire !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_no_overwrite got alu=%h mdu=%h lsu_fire=%b want tags 5,6 lsu_fire=0", alu_uop, mdu_uop, lsu_fire);
        end
        step();
        total++;
        if (dut.count !== 3'd2 || stall_out !== 1'b0 || alu_uop !== mk(2'd0, 8'd7) || lsu_fire !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_resume got cnt=%0d stall=%b alu=%h lsu_fire=%b want cnt=2 stall=0 tag 7 lsu_fire=0",
                            dut.count, stall_out, alu_uop, lsu_fire);
        end
        step();
        set_ready(0, 1, 0);
        total++;
        if (dut.count !== 3'd1 || lsu_fire !== 1'b1 || lsu_uop !== mk(2'd1, 8'd8)) begin
            bad++; $display("[TB] FAIL stall_last got cnt=%0d lsu_fire=%b uop=%h want cnt=1 fire=1 tag 8", dut.count, lsu_fire, lsu_uop);
        end
        step();
        set_ready(0, 0, 0);
    endtask

    task automatic test_compaction();
        inst0_in = mk(2'd0, 8'd99);
        inst0_in.valid = 1'b0;
        inst1_in = mk(2'd1, 8'd11);
        step();
        clear_inputs();
        total++;
        if (dut.count !== 3'd1 || dut.u_fifo.tail !== 2'd1) begin
            bad++; $display("[TB] FAIL compact_ptr got cnt=%0d tail=%0d want cnt=1 tail=1", dut.count, dut.u_fifo.tail);
        end
        set_ready(1, 1, 1);
        total++;
        if (lsu_fire !== 1'b1 || lsu_uop !== mk(2'd1, 8'd11) || alu_fire !== 1'b0) begin
            bad++; $display("[TB] FAIL compact_data got lsu_fire=%b uop=%h alu_fire=%b want 1 tag 11 0", lsu_fire, lsu_uop, alu_fire);
        end
        step();
        set_ready(0, 0, 0);
    endtask

    task automatic test_bus_default();
        inst0_in = mk(2'd3, 8'd20);
        step();
        clear_inputs();
        set_ready(1, 0, 0);
        total++;
        if (alu_fire !== 1'b1 || alu_uop !== mk(2'd3, 8'd20) || {lsu_fire, mdu_fire} !== 2'b00) begin
            bad++; $display("[TB] FAIL bus_default got alu_fire=%b uop=%h others=%b want 1 tag 20 00", alu_fire, alu_uop, {lsu_fire, mdu_fire});
        end
        step();
        set_ready(0, 0, 0);
    endtask

    task automatic test_flush();
        inst0_in = mk(2'd0, 8'd12);
        inst1_in = mk(2'd1, 8'd13);
        step();
        inst0_in = mk(2'd2, 8'd14);
        inst1_in = '0;
        step();
        total++;
        if (dut.count !== 3'd3 || stall_out !== 1'b1) begin
            bad++; $display("[TB] FAIL flush_setup got cnt=%0d stall=%b want cnt=3 stall=1", dut.count, stall_out);
        end
        flush = 1'b1;
        inst0_in = mk(2'd0, 8'd15);
        inst1_in = mk(2'd1, 8'd16);
        set_ready(1, 1, 1);
        total++;
        if ({alu_fire, lsu_fire, mdu_fire} !== 3'b000) begin
            bad++; $display("[TB] FAIL flush_fire got=%b want=000", {alu_fire, lsu_fire, mdu_fire});
        end
        step();
        flush = 1'b0;
        clear_inputs();
        total++;
        if (dut.count !== 3'd0 || stall_out !== 1'b0 || {alu_fire, lsu_fire, mdu_fire} !== 3'b000) begin
            bad++; $display("[TB] FAIL flush_after got cnt=%0d stall=%b fire=%b want 0 0 000", dut.count, stall_out, {alu_fire, lsu_fire, mdu_fire});
        end
        set_ready(0, 0, 0);
    endtask

    task automatic test_async_reset();
        inst0_in = mk(2'd0, 8'd17);
        inst1_in = mk(2'd2, 8'd18);
        step();
        clear_inputs();
        total++;
        if (dut.count !== 3'd2) begin bad++; $display("[TB] FAIL arst_setup got=%0d want=2", dut.count); end
        #1;
        rst = 1'b1;
        set_ready(1, 1, 1);
        total++;
        if (dut.count !== 3'd0 || stall_out !== 1'b0 || {alu_fire, lsu_fire, mdu_fire} !== 3'b000) begin
            bad++; $display("[TB] FAIL arst_now got cnt=%0d stall=%b fire=%b want 0 0 000", dut.count, stall_out, {alu_fire, lsu_fire, mdu_fire});
        end
        rst = 1'b0;
        step();
        total++;
        if (dut.count !== 3'd0 || {alu_fire, lsu_fire, mdu_fire} !== 3'b000) begin
            bad++; $display("[TB] FAIL arst_after got cnt=%0d fire=%b want 0 000", dut.count, {alu_fire, lsu_fire, mdu_fire});
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        inst0_in = '0;
        inst1_in = '0;
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        mdu_ready = 1'b0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_pair();
        test_in_order();
        test_stall();
        test_compaction();
        test_bus_default();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
